// File: rtl/pulse_period_decoder.sv
// -----------------------------------------------------------------------------
// pulse_period_decoder
//
// Recovers the load value of an upstream loadable counter by timing the gap
// between consecutive terminal-count pulses. The decoder arms on the first
// pulse. It then counts the idle cycles until the next pulse and reports that
// count as the load value.
//
// Ports
//   clk         in   1  single clock, rising edge
//   reset       in   1  asynchronous, active-high reset
//   pulse_i     in   1  terminal-count pulse stream, sampled on rising clk
//   clear_i     in   1  synchronous abort back to IDLE; overrides pulse_i
//   load_val_o  out  4  recovered load value, held until the next valid_o
//   valid_o     out  1  one-cycle strobe qualifying load_val_o
//   overflow_o  out  1  one-cycle strobe when a gap exceeds 15 idle cycles
//   busy_o      out  1  high while measuring a gap
//   match_o     out  1  strobe with valid_o when the value repeats the
//                       previous decode since the last IDLE entry
//
// Configuration
//   PULSE_DEC_MATCH_EN  when defined, builds the repeat-check logic that
//                       drives match_o. When undefined, match_o is tied to 0.
//
// Timing
//   valid_o and overflow_o rise one cycle after the edge that samples the
//   closing pulse or the over-long gap. The two strobes come from mutually
//   exclusive branches, so they are never high together.
// -----------------------------------------------------------------------------
module pulse_period_decoder (
  input  logic       clk,
  input  logic       reset,
  input  logic       pulse_i,
  input  logic       clear_i,
  output logic [3:0] load_val_o,
  output logic       valid_o,
  output logic       overflow_o,
  output logic       busy_o,
  output logic       match_o
);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] MEASURE = 1'b1;

  // Largest gap that still fits in the 4-bit load value.
  localparam logic [4:0] GAP_MAX = 5'd15;

  logic [0:0] state;
  logic [0:0] state_nxt;
  logic [4:0] gap_cnt;
  logic [4:0] gap_cnt_nxt;
  logic       decode;       // a closing pulse arrives on this edge
  logic       overflow_evt; // the gap grows past GAP_MAX on this edge

  // ---------------------------------------------------------------------------
  // Next-state and event decode
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default before any branch.
    // A path that left one of them unassigned would infer a latch.
    state_nxt    = state;
    gap_cnt_nxt  = gap_cnt;
    decode       = 1'b0;
    overflow_evt = 1'b0;

    if (clear_i) begin
      // The abort wins over any pulse sampled on the same edge.
      state_nxt   = IDLE;
      gap_cnt_nxt = '0;
    end else begin
      case (state)
        IDLE: begin
          if (pulse_i) begin
            state_nxt   = MEASURE;
            gap_cnt_nxt = '0;
          end
        end

        MEASURE: begin
          if (pulse_i) begin
            // gap_cnt never exceeds GAP_MAX while measuring, so every closing
            // pulse produces a valid decode.
            decode      = 1'b1;
            gap_cnt_nxt = '0;
          end else if (gap_cnt >= GAP_MAX) begin
            // The next increment would reach 16, which the 4-bit load value
            // cannot represent. Abandon the measurement.
            overflow_evt = 1'b1;
            gap_cnt_nxt  = '0;
            state_nxt    = IDLE;
          end else begin
            gap_cnt_nxt = gap_cnt + 5'd1;
          end
        end

        default: begin
          state_nxt   = IDLE;
          gap_cnt_nxt = '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State, counter and output registers
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments. All registers then
  // update together from values sampled before the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      gap_cnt    <= '0;
      load_val_o <= '0;
      valid_o    <= 1'b0;
      overflow_o <= 1'b0;
    end else begin
      state      <= state_nxt;
      gap_cnt    <= gap_cnt_nxt;
      valid_o    <= decode;
      overflow_o <= overflow_evt;
      // load_val_o keeps its last decoded value between strobes.
      if (decode) begin
        load_val_o <= gap_cnt[3:0];
      end
    end
  end

  assign busy_o = (state == MEASURE);

  // ---------------------------------------------------------------------------
  // Repeat check
  // ---------------------------------------------------------------------------
`ifdef PULSE_DEC_MATCH_EN
  logic [3:0] prev_val; // value of the previous decode
  logic       prev_ok;  // prev_val holds a decode made since the last IDLE entry

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_val <= '0;
      prev_ok  <= 1'b0;
      match_o  <= 1'b0;
    end else begin
      match_o <= decode && prev_ok && (gap_cnt[3:0] == prev_val);
      if (state_nxt == IDLE) begin
        // Entering or staying in IDLE clears the history. The first decode
        // after re-arming then never reports a match.
        prev_ok <= 1'b0;
      end else if (decode) begin
        prev_val <= gap_cnt[3:0];
        prev_ok  <= 1'b1;
      end
    end
  end
`else
  assign match_o = 1'b0;
`endif

endmodule

// File: doc/pulse_period_decoder.md
PULSE_PERIOD_DECODER -- requirements
Module: pulse_period_decoder

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port pulse_i, input, 1 bit: terminal-count pulse stream from the loadable counter, sampled on the rising edge of clk.
REQ-004 SHALL have port clear_i, input, 1 bit: synchronous abort; returns the decoder to IDLE.
REQ-005 SHALL have port load_val_o, output, 4 bits: recovered counter load value.
REQ-006 SHALL have port valid_o, output, 1 bit: one-cycle strobe qualifying load_val_o.
REQ-007 SHALL have port overflow_o, output, 1 bit: one-cycle strobe on a gap too long to encode.
REQ-008 SHALL have port busy_o, output, 1 bit: high while in MEASURE.
REQ-009 SHALL have port match_o, output, 1 bit: repeat-value flag (see Configuration).

Function
REQ-010 SHALL implement a two-state FSM, IDLE and MEASURE, plus a 5-bit gap counter gap_cnt.
REQ-011 SHALL, in IDLE with pulse_i=1, move to MEASURE and clear gap_cnt to 0; pulse_i=0 keeps IDLE.
REQ-012 SHALL, in MEASURE with pulse_i=0, increment gap_cnt by 1.
REQ-013 SHALL, in MEASURE with pulse_i=1 and gap_cnt<=15, register load_val_o=gap_cnt[3:0], assert valid_o for exactly the next cycle, clear gap_cnt to 0, and stay in MEASURE.
REQ-014 SHALL decode back-to-back pulses (gap_cnt=0) as load_val_o=0 with valid_o.
REQ-015 SHALL, when gap_cnt would increment from 15 to 16 (pulse_i=0), assert overflow_o for exactly the next cycle, clear gap_cnt, and return to IDLE without asserting valid_o.
REQ-016 SHALL, with clear_i=1, go to IDLE, clear gap_cnt, and suppress valid_o/overflow_o for that edge; clear_i has priority over pulse_i.
REQ-017 SHALL hold load_val_o at its last decoded value until the next valid_o.
REQ-018 SHALL never assert valid_o and overflow_o in the same cycle.
REQ-019 SHALL drive busy_o combinationally from state (1 in MEASURE, 0 in IDLE).
REQ-020 SHALL have one cycle of latency from the sampling edge of the closing pulse to valid_o.

Reset
REQ-021 SHALL, on reset=1, immediately force state=IDLE, gap_cnt=0, load_val_o=0, valid_o=0, overflow_o=0, match_o=0 and the previous-value register=0.
REQ-022 SHALL discard a measurement in progress on a mid-operation reset; the first pulse after release only arms the decoder.

Configuration
REQ-023 SHALL compile the repeat-check logic only when macro PULSE_DEC_MATCH_EN is defined.
REQ-024 SHALL, with PULSE_DEC_MATCH_EN defined, assert match_o together with valid_o when load_val_o equals the previous valid decode since the last IDLE entry.
REQ-025 SHALL, with PULSE_DEC_MATCH_EN defined, keep match_o=0 on the first valid decode after any IDLE entry.
REQ-026 SHALL, with PULSE_DEC_MATCH_EN undefined, keep the match_o port present and tie it to constant 0.

Verification
REQ-027 SHALL cover: reset, then pulse_i high on cycles 5 and 16 -> valid_o on cycle 17, load_val_o=10 (0xA).
REQ-028 SHALL cover: pulses on cycles 3 and 4 -> valid_o with load_val_o=0; a third pulse on cycle 20 -> valid_o with load_val_o=15.
REQ-029 SHALL cover: a pulse, then 16 idle cycles -> overflow_o one cycle, busy_o=0, no valid_o, and the next pulse only re-arms.
REQ-030 SHALL cover: clear_i=1 on the same edge as a closing pulse -> no valid_o, state IDLE; also reset mid-MEASURE -> all outputs 0 at once.
REQ-031 SHALL cover: with PULSE_DEC_MATCH_EN defined, a period-4 pulse train decodes 3,3,3 -> match_o pattern 0,1,1; with the macro undefined, match_o stays 0.
